inst_queue: RTL and testbench

- Circular FIFO of fetched instructions between the instruction-fetch unit and the decode/issue stage (ID).
- Fetch pushes {inst, pc} pairs.
- ID reads the head combinationally (first-word-fall-through) and pops it by asserting its dequeue enable in the cycle it issues.
- The ROB flushes the queue on branch mispredict.

---
 rtl/inst_queue_if.sv | 30 +++
 rtl/inst_queue.sv | 70 +++++++
 tb/tb_inst_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch/ID-facing bundle of the instruction queue: push side, pop side, control.
// Latency: n/a (wires only).
// Backpressure: IF_queue_is_full stalls fetch; ID_queue_is_empty gates ID pops.
interface inst_queue_if #(
    parameter int PTR_W = 4
);
    logic             rdy;
    logic             flush;
    logic             IF_valid;
    logic [31:0]      IF_inst;
    logic [31:0]      IF_pc;
    logic             IF_queue_is_full;
    logic             ID_enable;
    logic             ID_queue_is_empty;
    logic [31:0]      ID_inst;
    logic [31:0]      ID_pc;
    logic [PTR_W:0]   count;

    // Driver side: fetch, ID and ROB controls.
    modport master (
        output rdy, flush, IF_valid, IF_inst, IF_pc, ID_enable,
        input  IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc, count
    );

    // Queue side.
    modport slave (
        input  rdy, flush, IF_valid, IF_inst, IF_pc, ID_enable,
        output IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc, count
    );
endinterface

// File: rtl/inst_queue.sv
// Circular FWFT queue of {inst, pc} between fetch and decode/issue; flushed by ROB.
// Latency: push visible at head 1 cycle later; pop exposes next entry 1 cycle later.
// Backpressure: push refused while full (registered count), pop ignored while empty; rdy=0 freezes all.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    inst_queue_if.slave   q
);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   cnt;

    logic empty;
    logic full;
    logic push_ok;
    logic pop_ok;

    // Full/empty come from the registered count, so a same-cycle pop never frees room for a push.
    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign push_ok = q.rdy & ~q.flush & q.IF_valid  & ~full;
    assign pop_ok  = q.rdy & ~q.flush & q.ID_enable & ~empty;

    // Entry storage: written at the tail on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            inst_mem[tail] <= q.IF_inst;
            pc_mem[tail]   <= q.IF_pc;
        end
    end

    // Pointer and occupancy update; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (q.rdy) begin
            if (q.flush) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (push_ok) tail <= tail + PTR_ONE;
                if (pop_ok)  head <= head + PTR_ONE;
                case ({push_ok, pop_ok})
                    2'b10:   cnt <= cnt + CNT_ONE;
                    2'b01:   cnt <= cnt - CNT_ONE;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Head is read straight from storage; an empty queue presents zeros instead of stale data.
    assign q.ID_queue_is_empty = empty;
    assign q.IF_queue_is_full  = full;
    assign q.ID_inst           = empty ? 32'd0 : inst_mem[head];
    assign q.ID_pc             = empty ? 32'd0 : pc_mem[head];
    assign q.count             = cnt;
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic vs a queue model.
// Latency: model updated on posedge, compared on every negedge outside reset.
// Backpressure: model applies full/empty refusal from its own occupancy before the edge.
module tb_inst_queue;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_queue_if #(.PTR_W(PTR_W)) bus ();

    inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of {inst, pc}.
    logic [63:0] mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs present at the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else if (bus.rdy) begin
            if (bus.flush) begin
                mq.delete();
            end else begin
                bit do_push;
                bit do_pop;
                do_push = bus.IF_valid  && (mq.size() != DEPTH);
                do_pop  = bus.ID_enable && (mq.size() != 0);
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back({bus.IF_inst, bus.IF_pc});
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(bus.count), 32'(mq.size()));
            chk("empty", 32'(bus.ID_queue_is_empty), 32'(mq.size() == 0));
            chk("full",  32'(bus.IF_queue_is_full),  32'(mq.size() == DEPTH));
            chk("head_inst", bus.ID_inst, (mq.size() != 0) ? mq[0][63:32] : 32'd0);
            chk("head_pc",   bus.ID_pc,   (mq.size() != 0) ? mq[0][31:0]  : 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic en, input logic fl, input logic rd);
        bus.IF_valid  = v;
        bus.IF_inst   = inst;
        bus.IF_pc     = pc;
        bus.ID_enable = en;
        bus.flush     = fl;
        bus.rdy       = rd;
    endtask

    initial begin
        logic [31:0] pc_next;
        logic [31:0] exp_pop;
        logic [31:0] held_pc;
        logic [4:0]  held_cnt;

        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_empty", 32'(bus.ID_queue_is_empty), 32'd1);
        chk("reset_full",  32'(bus.IF_queue_is_full),  32'd0);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_inst",  bus.ID_inst, 32'd0);
        chk("reset_pc",    bus.ID_pc,   32'd0);

        // Single push visible one cycle later.
        drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("first_empty", 32'(bus.ID_queue_is_empty), 32'd0);
        chk("first_inst",  bus.ID_inst, 32'h00500093);
        chk("first_pc",    bus.ID_pc,   32'h0);
        chk("first_count", 32'(bus.count), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        cyc();

        // Fill to 16, refused 17th push, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h1000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0, 1'b1);
            cyc();
        end
        chk("fill_full",  32'(bus.IF_queue_is_full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        drive(1'b1, 32'hdead_beef, 32'h40, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("push17_count", 32'(bus.count), 32'd16);
        chk("push17_head",  bus.ID_pc, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", bus.ID_pc, 32'(i * 4));
            drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
            cyc();
        end
        chk("drain_empty", 32'(bus.ID_queue_is_empty), 32'd1);

        // Steady state at count 5 with simultaneous push and pop.
        pc_next = 32'h100;
        exp_pop = 32'h100;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ~pc_next, pc_next, 1'b0, 1'b0, 1'b1);
            pc_next += 4;
            cyc();
        end
        for (int i = 0; i < 20; i++) begin
            chk("steady_seq", bus.ID_pc, exp_pop);
            drive(1'b1, ~pc_next, pc_next, 1'b1, 1'b0, 1'b1);
            pc_next += 4;
            exp_pop += 4;
            cyc();
            chk("steady_count", 32'(bus.count), 32'd5);
        end

        // Top up to full, then push+pop together: pop only.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, ~pc_next, pc_next, 1'b0, 1'b0, 1'b1);
            pc_next += 4;
            cyc();
        end
        chk("full_again", 32'(bus.IF_queue_is_full), 32'd1);
        drive(1'b1, 32'h1234_5678, 32'h9999_0000, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("fullpp_count", 32'(bus.count), 32'd15);
        chk("fullpp_full",  32'(bus.IF_queue_is_full), 32'd0);

        // Drain to 7, then flush beats concurrent push and pop.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
            cyc();
        end
        chk("pre_flush_count", 32'(bus.count), 32'd7);
        drive(1'b1, 32'haaaa_aaaa, 32'h500, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_empty", 32'(bus.ID_queue_is_empty), 32'd1);
        chk("flush_inst",  bus.ID_inst, 32'd0);
        drive(1'b1, 32'h0000_0013, 32'h1000, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("post_flush_pc", bus.ID_pc, 32'h1000);

        // rdy low freezes everything.
        drive(1'b1, 32'h0000_0033, 32'h1004, 1'b0, 1'b0, 1'b1);
        cyc();
        held_cnt = bus.count;
        held_pc  = bus.ID_pc;
        drive(1'b1, 32'h0000_0093, 32'h1008, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("rdy0_count", 32'(bus.count), 32'(held_cnt));
        chk("rdy0_count_lit", 32'(bus.count), 32'd2);
        chk("rdy0_head",  bus.ID_pc, held_pc);
        chk("rdy0_head_lit", bus.ID_pc, 32'h1000);

        // Asynchronous reset mid-cycle clears outputs before any clock edge.
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_empty", 32'(bus.ID_queue_is_empty), 32'd1);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_pc",    bus.ID_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Randomized traffic with phases biased toward filling and draining.
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase = (i / 150) % 3;
            drive(($urandom_range(99) < (phase == 0 ? 85 : (phase == 1 ? 30 : 55))),
                  $urandom(), $urandom(),
                  ($urandom_range(99) < (phase == 0 ? 25 : (phase == 1 ? 85 : 55))),
                  ($urandom_range(199) == 0),
                  ($urandom_range(9) != 0));
            cyc();
        end

        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
